// File: rtl/vp_pkg.sv
// Shared definitions for the vp video source: pattern codes, colour-bar constants
// and the raster FSM state type.
package vp_pkg;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_GRAD  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Bar colours run left to right in classic SMPTE-like order.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vp_pattern_gen.sv
// Combinational test-pattern source: maps raster position and the latched
// pattern select to a 24-bit RGB pixel, forced to black outside the active area.
module vp_pattern_gen
  import vp_pkg::*;
#(
  parameter logic [23:0] SOLID_COLOR = 24'h808080
) (
  input  logic [1:0]  pat_q,
  input  logic [7:0]  h_cnt,
  input  logic [3:3]  v_cnt,
  input  logic [2:0]  bar_idx,
  input  logic        de,
  output logic [23:0] pixel
);

  always_comb begin
    pixel = 24'h0;
    if (de) begin
      case (pat_q)
        PAT_BARS:  pixel = bar_color(bar_idx);
        PAT_GRAD:  pixel = {h_cnt, h_cnt, h_cnt};
        PAT_CHECK: pixel = (h_cnt[3] ^ v_cnt[3]) ? 24'h000000 : 24'hFFFFFF;
        default:   pixel = SOLID_COLOR;
      endcase
    end
  end

endmodule

// File: rtl/vp_timing_gen.sv
// Raster timing generator: owns the h/v counters, run/idle FSM and the output
// registers that drive de/h_sync/v_sync/pixel into the vp pipeline.
module vp_timing_gen
  import vp_pkg::*;
#(
  parameter int          H_ACTIVE    = 1280,
  parameter int          H_FP        = 110,
  parameter int          H_SYNC      = 40,
  parameter int          H_BP        = 220,
  parameter int          V_ACTIVE    = 720,
  parameter int          V_FP        = 5,
  parameter int          V_SYNC      = 5,
  parameter int          V_BP        = 20,
  parameter logic        SYNC_POL    = 1'b1,
  parameter logic [23:0] SOLID_COLOR = 24'h808080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        de_out,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic [23:0] pixel_out,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] BAR_LAST   = HW'(H_ACTIVE / 8 - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  state_t        state, state_nxt;
  logic          cnt_valid, cnt_valid_nxt;
  logic [HW-1:0] h_cnt, h_nxt, bar_px, bar_px_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic [2:0]    bar_idx, bar_idx_nxt;
  logic [1:0]    pat_q, pat_nxt;
  logic          frame_end;

  logic          de_c, hs_c, vs_c, fs_c;
  logic [23:0]   pix_c;
  logic [7:0]    h_lo;
  logic [3:3]    v_b3;

  assign frame_end = cnt_valid && (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // cnt_valid spends one cycle at (0,0) after leaving IDLE so the first
  // active pixel reaches the outputs two edges after enable is seen.
  always_comb begin
    state_nxt     = state;
    cnt_valid_nxt = cnt_valid;
    h_nxt         = h_cnt;
    v_nxt         = v_cnt;
    bar_px_nxt    = bar_px;
    bar_idx_nxt   = bar_idx;
    pat_nxt       = pat_q;
    case (state)
      IDLE: begin
        cnt_valid_nxt = 1'b0;
        h_nxt         = '0;
        v_nxt         = '0;
        bar_px_nxt    = '0;
        bar_idx_nxt   = '0;
        if (enable) begin
          state_nxt = RUN;
          pat_nxt   = pattern_sel;
        end
      end
      default: begin
        if (!cnt_valid) begin
          cnt_valid_nxt = 1'b1;
        end else begin
          if (h_cnt == H_LAST) begin
            h_nxt       = '0;
            bar_px_nxt  = '0;
            bar_idx_nxt = '0;
            v_nxt       = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
          end else begin
            h_nxt = h_cnt + HW'(1);
            if (bar_px == BAR_LAST) begin
              bar_px_nxt  = '0;
              bar_idx_nxt = bar_idx + 3'd1;
            end else begin
              bar_px_nxt = bar_px + HW'(1);
            end
          end
          if (frame_end) begin
            if (!enable) begin
              state_nxt     = IDLE;
              cnt_valid_nxt = 1'b0;
            end else begin
              pat_nxt = pattern_sel;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt_valid <= 1'b0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      bar_px    <= '0;
      bar_idx   <= '0;
      pat_q     <= PAT_BARS;
    end else begin
      state     <= state_nxt;
      cnt_valid <= cnt_valid_nxt;
      h_cnt     <= h_nxt;
      v_cnt     <= v_nxt;
      bar_px    <= bar_px_nxt;
      bar_idx   <= bar_idx_nxt;
      pat_q     <= pat_nxt;
    end
  end

  // The pattern only needs the low byte of h and bit 3 of v; short counters are zero-extended.
  if (HW >= 8) begin : g_h_wide
    assign h_lo = h_cnt[7:0];
  end else begin : g_h_narrow
    assign h_lo = {{(8 - HW){1'b0}}, h_cnt};
  end
  if (VW >= 4) begin : g_v_wide
    assign v_b3 = v_cnt[3:3];
  end else begin : g_v_narrow
    assign v_b3 = 1'b0;
  end

  assign de_c = cnt_valid && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hs_c = (cnt_valid && (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  assign vs_c = (cnt_valid && (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  assign fs_c = cnt_valid && (h_cnt == '0) && (v_cnt == '0);

  vp_pattern_gen #(
    .SOLID_COLOR(SOLID_COLOR)
  ) u_pattern (
    .pat_q  (pat_q),
    .h_cnt  (h_lo),
    .v_cnt  (v_b3),
    .bar_idx(bar_idx),
    .de     (de_c),
    .pixel  (pix_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_out      <= 1'b0;
      h_sync_out  <= ~SYNC_POL;
      v_sync_out  <= ~SYNC_POL;
      pixel_out   <= 24'h0;
      frame_start <= 1'b0;
    end else begin
      de_out      <= de_c;
      h_sync_out  <= hs_c;
      v_sync_out  <= vs_c;
      pixel_out   <= pix_c;
      frame_start <= fs_c;
    end
  end

endmodule

// File: tb/tb_vp_timing_gen.sv
// Self-checking bench for vp_timing_gen: directed and randomised enable/pattern/reset
// stimulus compared every cycle against a raster-position model of the output stream.
module tb_vp_timing_gen;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int H_TOTAL  = 16;
  localparam int FRAME    = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        de_out;
  logic        h_sync_out;
  logic        v_sync_out;
  logic [23:0] pixel_out;
  logic        frame_start;

  vp_timing_gen #(
    .H_ACTIVE   (H_ACTIVE),
    .H_FP       (H_FP),
    .H_SYNC     (H_SYNC),
    .H_BP       (H_BP),
    .V_ACTIVE   (V_ACTIVE),
    .V_FP       (V_FP),
    .V_SYNC     (V_SYNC),
    .V_BP       (V_BP),
    .SYNC_POL   (1'b1),
    .SOLID_COLOR(24'h808080)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .de_out     (de_out),
    .h_sync_out (h_sync_out),
    .v_sync_out (v_sync_out),
    .pixel_out  (pixel_out),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Model: mPhase counts displayed cycles since a run began (negative while priming).
  bit          mRun;
  bit          mShow;
  int          mPhase;
  logic [1:0]  mPat;
  logic [1:0]  mPatNext;
  logic [23:0] barTable [8];

  task automatic modelEdge();
    if (!rst_n) begin
      mRun  = 0;
      mShow = 0;
      return;
    end
    if (!mRun) begin
      mShow = 0;
      if (enable) begin
        mRun   = 1;
        mPhase = -2;
        mPat   = pattern_sel;
      end
    end else begin
      mPhase++;
      mShow = (mPhase >= 0);
      if (mShow && mPhase > 0 && (mPhase % FRAME) == 0) mPat = mPatNext;
      if (mShow && (mPhase % FRAME) == FRAME - 1) begin
        if (!enable) mRun = 0;
        else mPatNext = pattern_sel;
      end
    end
  endtask

  function automatic logic [23:0] expPixel(logic [1:0] pat, int x, int y);
    logic [7:0] g;
    g = 8'(x);
    case (pat)
      2'd0:    return barTable[x / (H_ACTIVE / 8)];
      2'd1:    return {g, g, g};
      2'd2:    return ((((x / 8) % 2) ^ ((y / 8) % 2)) == 0) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h808080;
    endcase
  endfunction

  task automatic compare(string tag, logic [23:0] got, logic [23:0] exp);
    checkCount++;
    assert (got === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic checkOutput();
    int pos, x, y;
    logic eDe, eHs, eVs, eFs;
    logic [23:0] ePix;
    pos  = mShow ? (mPhase % FRAME) : 0;
    x    = pos % H_TOTAL;
    y    = pos / H_TOTAL;
    eDe  = mShow && (x < H_ACTIVE) && (y < V_ACTIVE);
    eHs  = mShow && (x >= H_ACTIVE + H_FP) && (x < H_ACTIVE + H_FP + H_SYNC);
    eVs  = mShow && (y >= V_ACTIVE + V_FP) && (y < V_ACTIVE + V_FP + V_SYNC);
    eFs  = mShow && (pos == 0);
    ePix = eDe ? expPixel(mPat, x, y) : 24'h0;
    compare("de", 24'(de_out), 24'(eDe));
    compare("h_sync", 24'(h_sync_out), 24'(eHs));
    compare("v_sync", 24'(v_sync_out), 24'(eVs));
    compare("frame_start", 24'(frame_start), 24'(eFs));
    compare("pixel", pixel_out, ePix);
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] sel, input int cycles);
    enable      = en;
    pattern_sel = sel;
    repeat (cycles) tick();
  endtask

  task automatic runUntilPos(input int p);
    int n;
    n = 0;
    while (!(mShow && (mPhase % FRAME) == p) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      checkCount++;
      failCount++;
      $error("[TB] FAIL wait_pos: got timeout expected position %0d", p);
    end
  endtask

  task automatic resetNow();
    rst_n = 1'b0;
    #1;
    mRun  = 0;
    mShow = 0;
    checkOutput();
  endtask

  initial begin
    int len;
    barTable = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    mRun = 0; mShow = 0; mPhase = 0; mPat = 2'd0; mPatNext = 2'd0;
    rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0;
    #2;
    checkOutput();
    repeat (3) tick();
    rst_n = 1'b1;

    $display("[TB] timing and bars");
    applyStimulus(1'b1, 2'd0, 2 * FRAME + 10);

    $display("[TB] latched select bars -> solid");
    runUntilPos(50);
    applyStimulus(1'b1, 2'd3, 2 * FRAME);

    $display("[TB] checker and gradient");
    applyStimulus(1'b1, 2'd2, FRAME + 20);
    applyStimulus(1'b1, 2'd1, 2 * FRAME);

    $display("[TB] enable drop mid-frame and re-enable");
    pattern_sel = 2'd0;
    runUntilPos(40);
    applyStimulus(1'b0, 2'd0, FRAME + 20);
    applyStimulus(1'b1, 2'd0, FRAME + 10);

    $display("[TB] asynchronous reset mid-frame");
    runUntilPos(70);
    resetNow();
    repeat (4) tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'd2, FRAME + 10);

    $display("[TB] randomised segments");
    for (int seg = 0; seg < 40; seg++) begin
      len         = $urandom_range(5, 300);
      enable      = ($urandom_range(0, 3) != 0);
      pattern_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        resetNow();
        repeat ($urandom_range(1, 4)) tick();
        rst_n = 1'b1;
      end
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 19) == 0) pattern_sel = 2'($urandom_range(0, 3));
        tick();
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
